// File: rtl/spi_trig_pkg.sv
// Shared types and helpers for the SPI protocol trigger: FSM states, frame width limits, effective length.
// Latency: n/a (declarations only). Backpressure: n/a.
// Flow: n/a.
package spi_trig_pkg;

  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  // A programmed length of zero, or one beyond the register width, means a full-width frame.
  function automatic int eff_len(input int frame_len, input int data_w);
    return ((frame_len == 0) || (frame_len > data_w)) ? data_w : frame_len;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchroniser chain for one asynchronous pin, plus an edge-detect flop giving rise/fall pulses.
// Latency: SYNC_STG clk to lvl, rise/fall valid in the same cycle as the new lvl.
// Backpressure: none, free-running.
module sync_edge #(
  parameter int   SYNC_STG = 3,
  parameter logic PRESET   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STG-1:0] sync_q;
  logic                edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STG{PRESET}};
      edge_q <= PRESET;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], din};
      edge_q <= sync_q[SYNC_STG-1];
    end
  end

  assign lvl  = sync_q[SYNC_STG-1];
  assign rise = lvl & ~edge_q;
  assign fall = ~lvl & edge_q;

endmodule

// File: rtl/spi_prot_trig.sv
// SPI bus snooper: captures each SS_n-framed MOSI word and pulses trig when it matches a masked pattern.
// Latency: trig/frame_vld 2 clk after the synchronised SS_n rise. Backpressure: none, results are pulses.
// Optional SPI_TRIG_CNT_EN adds a saturating match counter (match_cnt) with clear input cnt_clr.
module spi_prot_trig
  import spi_trig_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int SYNC_STG = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        SS_n,
  input  logic                        SCLK,
  input  logic                        MOSI,
  input  logic                        armed,
  input  logic                        pos_edge,
  input  logic [$clog2(DATA_W+1)-1:0] frame_len,
  input  logic [DATA_W-1:0]           match,
  input  logic [DATA_W-1:0]           mask,
`ifdef SPI_TRIG_CNT_EN
  input  logic                        cnt_clr,
  output logic [15:0]                 match_cnt,
`endif
  output logic                        trig,
  output logic [DATA_W-1:0]           frame_data,
  output logic                        frame_vld
);

  localparam int            CW      = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(DATA_W + 1);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  sync_edge #(.SYNC_STG(SYNC_STG), .PRESET(1'b1)) u_ss (
    .clk(clk), .rst(rst), .din(SS_n), .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );
  sync_edge #(.SYNC_STG(SYNC_STG), .PRESET(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(SCLK), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.SYNC_STG(SYNC_STG), .PRESET(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(MOSI), .lvl(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};

  state_t            state, state_nxt;
  logic              fall_pend;
  logic              start, shift_en, check_st, sclk_edge;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] len_mask;
  logic              len_ok, hit;
  int                len;

  assign sclk_edge = pos_edge ? sclk_rise : sclk_fall;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall || fall_pend) state_nxt = SHIFT;
      SHIFT:   if (ss_rise) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An SCLK edge coincident with the SS_n rise belongs to no frame and is dropped.
  always_comb begin
    start    = 1'b0;
    shift_en = 1'b0;
    check_st = 1'b0;
    case (state)
      IDLE:    start    = ss_fall || fall_pend;
      SHIFT:   shift_en = sclk_edge && !ss_rise;
      CHECK:   check_st = 1'b1;
      default: ;
    endcase
  end

  // SS_n can drop again while CHECK is busy; remember it so IDLE starts the next frame.
  always_ff @(posedge clk) begin
    if (rst)                           fall_pend <= 1'b0;
    else if (state == CHECK && ss_fall) fall_pend <= 1'b1;
    else if (state == IDLE)            fall_pend <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[DATA_W-2:0], mosi_lvl};
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
    end
  end

  always_comb begin
    len      = eff_len(int'(frame_len), DATA_W);
    len_mask = '0;
    for (int i = 0; i < DATA_W; i++) len_mask[i] = (i < len);
    len_ok   = (int'(bit_cnt) == len);
    hit      = (((shreg ^ match) & mask & len_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig       <= 1'b0;
      frame_vld  <= 1'b0;
      frame_data <= '0;
    end else begin
      frame_vld <= check_st && len_ok;
      trig      <= check_st && len_ok && armed && hit;
      if (check_st && len_ok) frame_data <= shreg & len_mask;
    end
  end

`ifdef SPI_TRIG_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)                 match_cnt <= '0;
    else if (trig && match_cnt != 16'hFFFF) match_cnt <= match_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_spi_prot_trig.sv
// Directed bench for spi_prot_trig: table of frames with hand-computed results plus multi-cycle corner sequences.
// Optional counter checks are compiled when SPI_TRIG_CNT_EN is defined.
module tb_spi_prot_trig;

  localparam int DATA_W   = 16;
  localparam int SYNC_STG = 3;
  localparam int LAT      = SYNC_STG + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n, SCLK, MOSI;
  logic        armed, pos_edge;
  logic [4:0]  frame_len;
  logic [15:0] match, mask;
  logic        trig, frame_vld;
  logic [15:0] frame_data;
`ifdef SPI_TRIG_CNT_EN
  logic        cnt_clr;
  logic [15:0] match_cnt;
`endif

  spi_prot_trig #(.DATA_W(DATA_W), .SYNC_STG(SYNC_STG)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .armed(armed), .pos_edge(pos_edge), .frame_len(frame_len),
    .match(match), .mask(mask),
`ifdef SPI_TRIG_CNT_EN
    .cnt_clr(cnt_clr), .match_cnt(match_cnt),
`endif
    .trig(trig), .frame_data(frame_data), .frame_vld(frame_vld)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int vld_q[$];
  int trig_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (frame_vld) vld_q.push_back(cyc);
    if (trig)      trig_q.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    SS_n = 1'b0;
    tick(8);
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      MOSI = val[i];
      tick(2);
      SCLK = 1'b1;
      tick(3);
      SCLK = 1'b0;
      tick(2);
    end
  endtask

  task automatic end_frame(output int nv, output int nt, output int lat);
    int r;
    vld_q.delete();
    trig_q.delete();
    SS_n = 1'b1;
    r = cyc;
    tick(12);
    nv  = vld_q.size();
    nt  = trig_q.size();
    lat = (nv > 0) ? vld_q[0] - r : -1;
  endtask

  task automatic run_frame(input logic [31:0] val, input int n,
                           output int nv, output int nt, output int lat);
    start_frame();
    send_bits(val, n);
    end_frame(nv, nt, lat);
  endtask

  typedef struct {
    logic [31:0] val;
    int          nbits;
    logic [4:0]  len;
    logic        pe;
    logic [15:0] mt;
    logic [15:0] mk;
    logic        arm;
    int          exp_nv;
    int          exp_nt;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int nv, nt, lat, r1, r2, l0, l1;

    vecs[0] = '{32'h96,    8,  5'd8,  1'b0, 16'h0096, 16'h00FF, 1'b1, 1, 1, 16'h0096};
    vecs[1] = '{32'h97,    8,  5'd8,  1'b0, 16'h0096, 16'h00FF, 1'b1, 1, 0, 16'h0097};
    vecs[2] = '{32'h97,    8,  5'd8,  1'b0, 16'h0096, 16'h00FE, 1'b1, 1, 1, 16'h0097};
    vecs[3] = '{32'h66A5,  16, 5'd16, 1'b0, 16'h6600, 16'hFF00, 1'b1, 1, 1, 16'h66A5};
    vecs[4] = '{32'h3355,  15, 5'd16, 1'b0, 16'h6600, 16'hFF00, 1'b1, 0, 0, 16'h66A5};
    vecs[5] = '{32'h6600,  16, 5'd16, 1'b0, 16'h6600, 16'hFF00, 1'b0, 1, 0, 16'h6600};
    vecs[6] = '{32'hC3,    8,  5'd8,  1'b1, 16'hABC3, 16'hFFFF, 1'b1, 1, 1, 16'h00C3};
    vecs[7] = '{32'h1234,  16, 5'd0,  1'b0, 16'h1234, 16'hFFFF, 1'b1, 1, 1, 16'h1234};
    vecs[8] = '{32'h12345, 17, 5'd16, 1'b0, 16'h1234, 16'hFFFF, 1'b1, 0, 0, 16'h1234};
    vecs[9] = '{32'hBEEF,  16, 5'd31, 1'b0, 16'hBEEF, 16'hFFFF, 1'b1, 1, 1, 16'hBEEF};

    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    armed = 1'b0; pos_edge = 1'b0; frame_len = 5'd8; match = '0; mask = '0;
`ifdef SPI_TRIG_CNT_EN
    cnt_clr = 1'b0;
`endif
    tick(4);
    check("rst_trig", {31'd0, trig}, 32'd0);
    check("rst_vld", {31'd0, frame_vld}, 32'd0);
    check("rst_data", {16'd0, frame_data}, 32'd0);
    rst = 1'b0;
    tick(10);

    for (int v = 0; v < 10; v++) begin
      frame_len = vecs[v].len;
      pos_edge  = vecs[v].pe;
      match     = vecs[v].mt;
      mask      = vecs[v].mk;
      armed     = vecs[v].arm;
      run_frame(vecs[v].val, vecs[v].nbits, nv, nt, lat);
      check($sformatf("v%0d_vld", v), nv, vecs[v].exp_nv);
      check($sformatf("v%0d_trig", v), nt, vecs[v].exp_nt);
      check($sformatf("v%0d_data", v), {16'd0, frame_data}, {16'd0, vecs[v].exp_data});
      if (vecs[v].exp_nv == 1) check($sformatf("v%0d_lat", v), lat, LAT);
    end

    // Reset in the middle of a frame: the partial frame must vanish.
    frame_len = 5'd16; pos_edge = 1'b0; match = 16'h6600; mask = 16'hFF00; armed = 1'b1;
    start_frame();
    send_bits(32'h66, 5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    check("midrst_data", {16'd0, frame_data}, 32'd0);
    end_frame(nv, nt, lat);
    check("midrst_tail_vld", nv, 0);
    check("midrst_tail_trig", nt, 0);
    run_frame(32'h6600, 16, nv, nt, lat);
    check("postrst_trig", nt, 1);
    check("postrst_vld", nv, 1);
    check("postrst_data", {16'd0, frame_data}, 32'h6600);

    // Back-to-back frames separated by a single clk of SS_n high.
    frame_len = 5'd8; match = 16'h0096; mask = 16'h00FF;
    vld_q.delete();
    trig_q.delete();
    start_frame();
    send_bits(32'h96, 8);
    SS_n = 1'b1;
    r1 = cyc;
    tick(1);
    SS_n = 1'b0;
    tick(8);
    send_bits(32'h96, 8);
    SS_n = 1'b1;
    r2 = cyc;
    tick(12);
    l0 = (trig_q.size() > 0) ? trig_q[0] - r1 : -1;
    l1 = (trig_q.size() > 1) ? trig_q[1] - r2 : -1;
    check("b2b_trig_cnt", trig_q.size(), 2);
    check("b2b_vld_cnt", vld_q.size(), 2);
    check("b2b_lat0", l0, LAT);
    check("b2b_lat1", l1, LAT);

`ifdef SPI_TRIG_CNT_EN
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    tick(1);
    check("cnt_clr", {16'd0, match_cnt}, 32'd0);
    repeat (3) run_frame(32'h96, 8, nv, nt, lat);
    check("cnt_three", {16'd0, match_cnt}, 32'd3);
    start_frame();
    send_bits(32'h96, 8);
    SS_n = 1'b1;
    tick(LAT);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    tick(8);
    check("cnt_clr_vs_trig", {16'd0, match_cnt}, 32'd0);
    force dut.match_cnt = 16'hFFFF;
    tick(1);
    release dut.match_cnt;
    run_frame(32'h96, 8, nv, nt, lat);
    check("cnt_sat_trig", nt, 1);
    check("cnt_sat", {16'd0, match_cnt}, 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_prot_trig.md
SPI_PROT_TRIG -- requirements
Module: spi_prot_trig

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 16, giving the maximum frame length in bits (legal 8..32).
REQ-002 The block SHALL have the parameter SYNC_STG, default 3, giving the number of synchroniser flops per SPI input (legal 2..4).
REQ-003 clk  input  1  system clock; the block SHALL use a single clock domain.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 SS_n, SCLK, MOSI  input  1 each  asynchronous SPI pins under observation.
REQ-006 armed  input  1  enables trigger detection; when low, frames are tracked but trig SHALL NOT assert.
REQ-007 pos_edge  input  1  1 = sample MOSI on SCLK rise, 0 = sample on SCLK fall.
REQ-008 frame_len  input  $clog2(DATA_W+1)  expected bits per frame; 0 SHALL mean DATA_W, and values above DATA_W SHALL saturate to DATA_W.
REQ-009 match, mask  input  DATA_W each  compare value and care-mask (1 = compare that bit).
REQ-010 trig  output  1  one-cycle pulse on a matching frame.
REQ-011 frame_data  output  DATA_W  last complete frame, right-justified, zero-extended above frame_len.
REQ-012 frame_vld  output  1  one-cycle pulse on every complete frame, whether or not it matches.

Function
REQ-013 Each pin SHALL pass through SYNC_STG flops followed by one extra edge-detect flop; all logic SHALL use the synchronised versions only.
REQ-014 The FSM SHALL have three states: IDLE, SHIFT, CHECK.
REQ-015 IDLE -> SHIFT on a synchronised SS_n fall; at this transition bit_cnt SHALL clear and the shift register SHALL clear.
REQ-016 In SHIFT, on each selected SCLK edge, MOSI SHALL shift in at LSB (MSB-first wire order), and bit_cnt SHALL increment, saturating at DATA_W+1.
REQ-017 SHIFT -> CHECK on a synchronised SS_n rise.
REQ-018 An SCLK edge in the same cycle as the SS_n rise SHALL be ignored.
REQ-019 CHECK -> IDLE unconditionally after one cycle.
REQ-020 In CHECK, if bit_cnt equals the effective frame_len, the block SHALL update frame_data and pulse frame_vld in the next cycle.
REQ-021 In that same next cycle, trig SHALL pulse if armed and ((shreg ^ match) & mask) is zero over bits [len-1:0]; mask bits at or above len SHALL be ignored.
REQ-022 A short or long frame (bit_cnt != len) SHALL be discarded: no frame_vld, no trig, frame_data held.
REQ-023 Latency SHALL be fixed: trig and frame_vld high exactly 2 clk after the cycle in which the synchronised SS_n rise is detected.
REQ-024 armed, match, mask, frame_len and pos_edge SHALL be sampled in the CHECK cycle; changes mid-frame to pos_edge SHALL take effect at the next edge.
REQ-025 An SS_n fall during CHECK SHALL be caught on the following cycle in IDLE, with no frame lost for a gap of at least 1 clk.

Reset
REQ-026 Under rst, the state SHALL be IDLE.
REQ-027 Under rst, trig, frame_vld, frame_data, shreg and bit_cnt SHALL be 0.
REQ-028 Under rst, the SS_n synchroniser and edge flops SHALL preset to 1; the SCLK and MOSI flops SHALL preset to 0.
REQ-029 Reset mid-frame SHALL abandon the frame; the first frame counted after reset SHALL begin at the next SS_n fall seen after reset.

Configuration
REQ-030 With SPI_TRIG_CNT_EN defined, the block SHALL add output match_cnt (16 bits) that increments on each trig, saturates at 16'hFFFF, and clears on rst or on input cnt_clr (1 bit, priority over increment).
REQ-031 Without SPI_TRIG_CNT_EN, the match_cnt and cnt_clr ports and their logic SHALL be absent.

Structure
REQ-032 Package spi_trig_pkg SHALL hold the FSM state enum (IDLE/SHIFT/CHECK), DATA_W limits, and a function eff_len(frame_len, DATA_W).
REQ-033 Sub-module sync_edge (parametrised by SYNC_STG and preset value) SHALL provide the synchronised level plus rise and fall pulses, instantiated three times.

Verification
REQ-034 DATA_W=16, len=8, pos_edge=0, match=8'h96, mask=8'hFF, armed=1; SPI frame 8'h96 -> frame_vld=1, trig=1, frame_data=16'h0096.
REQ-035 Same config, frame 8'h97 -> frame_vld=1, trig=0; then mask=8'hFE with frame 8'h97 -> trig=1.
REQ-036 len=16, match=16'h6600, mask=16'hFF00; frame 16'h66A5 -> trig=1, frame_data=16'h66A5; 15-bit frame -> no frame_vld, frame_data unchanged.
REQ-037 armed=0 with frame 16'h6600 -> frame_vld=1, trig=0; rst asserted after 5 bits, then a full frame 16'h6600 -> trig=1 exactly once.
REQ-038 Back-to-back frames with 1-clk SS_n high gap, both matching -> two trig pulses, each 2 clk after the synchronised SS_n rise.
REQ-039 SPI_TRIG_CNT_EN defined: 3 matches -> match_cnt=3; cnt_clr asserted with a trig in the same cycle -> match_cnt=0; forced to 16'hFFFF plus one match -> stays 16'hFFFF.
